// File: rtl/control_unit_pkg.sv
// Shared definitions for the hardwired CPU control unit: opcodes, step states, strobe bundle.
package cpu_defs;

    localparam logic [4:0] OpLd   = 5'b00000;
    localparam logic [4:0] OpLdi  = 5'b00001;
    localparam logic [4:0] OpSt   = 5'b00010;
    localparam logic [4:0] OpAdd  = 5'b00011;
    localparam logic [4:0] OpSub  = 5'b00100;
    localparam logic [4:0] OpShr  = 5'b00101;
    localparam logic [4:0] OpShra = 5'b00110;
    localparam logic [4:0] OpShl  = 5'b00111;
    localparam logic [4:0] OpRor  = 5'b01000;
    localparam logic [4:0] OpRol  = 5'b01001;
    localparam logic [4:0] OpAnd  = 5'b01010;
    localparam logic [4:0] OpOr   = 5'b01011;
    localparam logic [4:0] OpAddi = 5'b01100;
    localparam logic [4:0] OpAndi = 5'b01101;
    localparam logic [4:0] OpOri  = 5'b01110;
    localparam logic [4:0] OpMul  = 5'b01111;
    localparam logic [4:0] OpDiv  = 5'b10000;
    localparam logic [4:0] OpNeg  = 5'b10001;
    localparam logic [4:0] OpNot  = 5'b10010;
    localparam logic [4:0] OpBr   = 5'b10011;
    localparam logic [4:0] OpJr   = 5'b10100;
    localparam logic [4:0] OpIn   = 5'b10110;
    localparam logic [4:0] OpOut  = 5'b10111;
    localparam logic [4:0] OpMfhi = 5'b11000;
    localparam logic [4:0] OpMflo = 5'b11001;
    localparam logic [4:0] OpNop  = 5'b11010;
    localparam logic [4:0] OpHalt = 5'b11011;

    typedef enum logic [3:0] {
        StT0, StT1, StT2, StT3, StT4, StT5, StT6, StT7, StStopped, StHalt
    } state_t;

    // Every datapath strobe driven in a single step, plus the ALU code and illegal flag.
    typedef struct packed {
        logic       pc_out, zlow_out, zhigh_out, mdr_out, hi_out, lo_out, c_out, inport_out;
        logic       pc_in, ir_in, mar_in, mdr_in, y_in, zlow_in, zhigh_in, hi_in, lo_in;
        logic       outport_in, con_in;
        logic       inc_pc, read, ram_we;
        logic       gra, grb, grc, r_in, r_out, ba_out;
        logic [4:0] operation;
        logic       illegal_op;
    } strobes_t;

endpackage

// File: rtl/control_unit_if.sv
// Control unit <-> datapath/board bundle: IR/CON feedback, run/stop handshake, all strobes.
interface control_unit_if;

    logic [31:0] ir;
    logic        con, stop, run, halted, illegal_op;
    logic        PCout, ZLowout, ZHighout, MDRout, HIout, LOout, Cout, InPortout;
    logic        PCin, IRin, MARin, MDRin, Yin, ZLowIn, ZHighIn, HIin, LOin, OutPortIn, CONin;
    logic        IncPC, Read, ramWE;
    logic        Gra, Grb, Grc, R_in, R_out, BAout;
    logic [4:0]  operation;

    modport master (
        input  ir, con, stop,
        output run, halted, illegal_op,
        output PCout, ZLowout, ZHighout, MDRout, HIout, LOout, Cout, InPortout,
        output PCin, IRin, MARin, MDRin, Yin, ZLowIn, ZHighIn, HIin, LOin, OutPortIn, CONin,
        output IncPC, Read, ramWE, Gra, Grb, Grc, R_in, R_out, BAout, operation
    );

    modport slave (
        output ir, con, stop,
        input  run, halted, illegal_op,
        input  PCout, ZLowout, ZHighout, MDRout, HIout, LOout, Cout, InPortout,
        input  PCin, IRin, MARin, MDRin, Yin, ZLowIn, ZHighIn, HIin, LOin, OutPortIn, CONin,
        input  IncPC, Read, ramWE, Gra, Grb, Grc, R_in, R_out, BAout, operation
    );

endinterface

// File: rtl/control_unit_mem_wait_counter.sv
// Down-counter that stretches a RAM read step by a loaded number of wait cycles.
module mem_wait_counter (
    input  logic       clk,
    input  logic       clr,
    input  logic       load_i,
    input  logic [2:0] load_val_i,
    input  logic       dec_i,
    output logic       done_o
);

    logic [2:0] cnt_q, cnt_d;

    // Load on entry to a read step, then count down to zero while the step is held.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != 3'd0)) begin
            cnt_d = cnt_q - 3'd1;
        end
    end

    // Count register, cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cnt_q <= 3'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == 3'd0);

endmodule

// File: rtl/control_unit.sv
// Hardwired fetch/decode/execute sequencer driving every datapath strobe as a Moore output.
module control_unit
    import cpu_defs::*;
#(
    parameter int unsigned MEM_WAIT = 0,
    parameter logic [4:0]  ADD_OP   = 5'b00011
) (
    input logic            clk,
    input logic            clr,
    control_unit_if.master bus
);

    state_t     state_q, state_d;
    strobes_t   s, s_g;
    logic [4:0] op;
    logic       fin, wait_done, wait_load, read_step;
    logic       is_rr, is_imm, is_muldiv, is_negnot, is_mem;

    assign op        = bus.ir[31:27];
    assign is_rr     = (op >= OpAdd) && (op <= OpOr);
    assign is_imm    = (op == OpAddi) || (op == OpAndi) || (op == OpOri);
    assign is_muldiv = (op == OpMul) || (op == OpDiv);
    assign is_negnot = (op == OpNeg) || (op == OpNot);
    assign is_mem    = (op == OpLd) || (op == OpLdi) || (op == OpSt);

    // Both RAM read steps (fetch T1, ld T6) share the wait counter.
    assign read_step = (state_q == StT1) || ((state_q == StT6) && (op == OpLd));
    assign wait_load = (state_d != state_q) &&
                       ((state_d == StT1) || ((state_d == StT6) && (op == OpLd)));

    mem_wait_counter u_wait (
        .clk        (clk),
        .clr        (clr),
        .load_i     (wait_load),
        .load_val_i (3'(MEM_WAIT)),
        .dec_i      (read_step),
        .done_o     (wait_done)
    );

    // Step register; reset abandons any instruction in flight.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= StT0;
        end else begin
            state_q <= state_d;
        end
    end

    // Next step and per-step strobes; fin marks the last step of an instruction.
    always_comb begin
        s       = '0;
        state_d = state_q;
        fin     = 1'b0;
        unique case (state_q)
            StT0: begin
                s.pc_out = 1'b1; s.mar_in = 1'b1; s.inc_pc = 1'b1;
                state_d  = StT1;
            end
            StT1: begin
                s.read = 1'b1;
                if (wait_done) begin
                    s.mdr_in = 1'b1;
                    state_d  = StT2;
                end
            end
            StT2: begin
                s.mdr_out = 1'b1; s.ir_in = 1'b1;
                state_d   = StT3;
            end
            StT3: begin
                state_d = StT4;
                if (is_rr || is_imm) begin
                    s.grb = 1'b1; s.r_out = 1'b1; s.y_in = 1'b1;
                end else if (is_muldiv) begin
                    s.gra = 1'b1; s.r_out = 1'b1; s.y_in = 1'b1;
                end else if (is_negnot) begin
                    s.grb = 1'b1; s.r_out = 1'b1; s.operation = op; s.zlow_in = 1'b1;
                end else if (is_mem) begin
                    s.grb = 1'b1; s.ba_out = 1'b1; s.y_in = 1'b1;
                end else begin
                    case (op)
                        OpBr:   begin s.gra = 1'b1; s.r_out = 1'b1; s.con_in = 1'b1; end
                        OpJr:   begin s.gra = 1'b1; s.r_out = 1'b1; s.pc_in = 1'b1; fin = 1'b1; end
                        OpIn:   begin s.inport_out = 1'b1; s.gra = 1'b1; s.r_in = 1'b1; fin = 1'b1; end
                        OpOut:  begin s.gra = 1'b1; s.r_out = 1'b1; s.outport_in = 1'b1; fin = 1'b1; end
                        OpMfhi: begin s.hi_out = 1'b1; s.gra = 1'b1; s.r_in = 1'b1; fin = 1'b1; end
                        OpMflo: begin s.lo_out = 1'b1; s.gra = 1'b1; s.r_in = 1'b1; fin = 1'b1; end
                        OpNop:  fin = 1'b1;
                        OpHalt: state_d = StHalt;
                        default: begin s.illegal_op = 1'b1; fin = 1'b1; end
                    endcase
                end
            end
            StT4: begin
                state_d = StT5;
                if (is_rr) begin
                    s.grc = 1'b1; s.r_out = 1'b1; s.operation = op; s.zlow_in = 1'b1;
                end else if (is_imm) begin
                    s.c_out = 1'b1; s.operation = op; s.zlow_in = 1'b1;
                end else if (is_muldiv) begin
                    s.grb = 1'b1; s.r_out = 1'b1; s.operation = op;
                    s.zlow_in = 1'b1; s.zhigh_in = 1'b1;
                end else if (is_negnot) begin
                    s.zlow_out = 1'b1; s.gra = 1'b1; s.r_in = 1'b1; fin = 1'b1;
                end else if (is_mem) begin
                    s.c_out = 1'b1; s.operation = ADD_OP; s.zlow_in = 1'b1;
                end else if (op == OpBr) begin
                    s.pc_out = 1'b1; s.y_in = 1'b1;
                end else begin
                    fin = 1'b1;
                end
            end
            StT5: begin
                state_d = StT6;
                if (is_rr || is_imm || (op == OpLdi)) begin
                    s.zlow_out = 1'b1; s.gra = 1'b1; s.r_in = 1'b1; fin = 1'b1;
                end else if (is_muldiv) begin
                    s.zlow_out = 1'b1; s.lo_in = 1'b1;
                end else if ((op == OpLd) || (op == OpSt)) begin
                    s.zlow_out = 1'b1; s.mar_in = 1'b1;
                end else if (op == OpBr) begin
                    s.c_out = 1'b1; s.operation = ADD_OP; s.zlow_in = 1'b1;
                end else begin
                    fin = 1'b1;
                end
            end
            StT6: begin
                state_d = StT7;
                if (is_muldiv) begin
                    s.zhigh_out = 1'b1; s.hi_in = 1'b1; fin = 1'b1;
                end else if (op == OpLd) begin
                    s.read = 1'b1;
                    if (wait_done) s.mdr_in = 1'b1;
                    else           state_d = StT6;
                end else if (op == OpSt) begin
                    s.gra = 1'b1; s.r_out = 1'b1; s.mdr_in = 1'b1;
                end else if (op == OpBr) begin
                    s.zlow_out = 1'b1; s.pc_in = bus.con; fin = 1'b1;
                end else begin
                    fin = 1'b1;
                end
            end
            StT7: begin
                fin = 1'b1;
                if (op == OpLd) begin
                    s.mdr_out = 1'b1; s.gra = 1'b1; s.r_in = 1'b1;
                end else if (op == OpSt) begin
                    s.ram_we = 1'b1;
                end
            end
            StStopped: if (!bus.stop) state_d = StT0;
            StHalt:    state_d = StHalt;
            default:   state_d = StT0;
        endcase
        // stop is only honoured at an instruction boundary.
        if (fin) state_d = bus.stop ? StStopped : StT0;
    end

    // Strobes are forced low while reset is held, even though the reset step is T0.
    assign s_g = clr ? s : '0;

    assign bus.run        = (state_q != StStopped) && (state_q != StHalt);
    assign bus.halted     = (state_q == StHalt);
    assign bus.illegal_op = s_g.illegal_op;
    assign bus.PCout      = s_g.pc_out;
    assign bus.ZLowout    = s_g.zlow_out;
    assign bus.ZHighout   = s_g.zhigh_out;
    assign bus.MDRout     = s_g.mdr_out;
    assign bus.HIout      = s_g.hi_out;
    assign bus.LOout      = s_g.lo_out;
    assign bus.Cout       = s_g.c_out;
    assign bus.InPortout  = s_g.inport_out;
    assign bus.PCin       = s_g.pc_in;
    assign bus.IRin       = s_g.ir_in;
    assign bus.MARin      = s_g.mar_in;
    assign bus.MDRin      = s_g.mdr_in;
    assign bus.Yin        = s_g.y_in;
    assign bus.ZLowIn     = s_g.zlow_in;
    assign bus.ZHighIn    = s_g.zhigh_in;
    assign bus.HIin       = s_g.hi_in;
    assign bus.LOin       = s_g.lo_in;
    assign bus.OutPortIn  = s_g.outport_in;
    assign bus.CONin      = s_g.con_in;
    assign bus.IncPC      = s_g.inc_pc;
    assign bus.Read       = s_g.read;
    assign bus.ramWE      = s_g.ram_we;
    assign bus.Gra        = s_g.gra;
    assign bus.Grb        = s_g.grb;
    assign bus.Grc        = s_g.grc;
    assign bus.R_in       = s_g.r_in;
    assign bus.R_out      = s_g.r_out;
    assign bus.BAout      = s_g.ba_out;
    assign bus.operation  = s_g.operation;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench: per-instruction strobe sequences queued from a table, checked every cycle.
module tb_control_unit;

    localparam int unsigned MW = 2;

    localparam logic [4:0] OLd = 5'd0, OLdi = 5'd1, OSt = 5'd2, OAdd = 5'd3, OOr = 5'd11;
    localparam logic [4:0] OAddi = 5'd12, OAndi = 5'd13, OOri = 5'd14, OMul = 5'd15;
    localparam logic [4:0] ODiv = 5'd16, ONeg = 5'd17, ONot = 5'd18, OBr = 5'd19, OJr = 5'd20;
    localparam logic [4:0] OIn = 5'd22, OOut = 5'd23, OMfhi = 5'd24, OMflo = 5'd25;
    localparam logic [4:0] ONop = 5'd26, OHalt = 5'd27;

    localparam logic [35:0] SBaOut = 36'd1 << 5,  SROut = 36'd1 << 6,  SRIn = 36'd1 << 7;
    localparam logic [35:0] SGrc = 36'd1 << 8,    SGrb = 36'd1 << 9,   SGra = 36'd1 << 10;
    localparam logic [35:0] SRamWe = 36'd1 << 11, SRead = 36'd1 << 12, SIncPc = 36'd1 << 13;
    localparam logic [35:0] SConIn = 36'd1 << 14, SOutPortIn = 36'd1 << 15;
    localparam logic [35:0] SLoIn = 36'd1 << 16,  SHiIn = 36'd1 << 17, SZHighIn = 36'd1 << 18;
    localparam logic [35:0] SZLowIn = 36'd1 << 19, SYIn = 36'd1 << 20, SMdrIn = 36'd1 << 21;
    localparam logic [35:0] SMarIn = 36'd1 << 22, SIrIn = 36'd1 << 23, SPcIn = 36'd1 << 24;
    localparam logic [35:0] SInPortOut = 36'd1 << 25, SCOut = 36'd1 << 26;
    localparam logic [35:0] SLoOut = 36'd1 << 27, SHiOut = 36'd1 << 28, SMdrOut = 36'd1 << 29;
    localparam logic [35:0] SZHighOut = 36'd1 << 30, SZLowOut = 36'd1 << 31;
    localparam logic [35:0] SPcOut = 36'd1 << 32, SIllegal = 36'd1 << 33;
    localparam logic [35:0] SHalted = 36'd1 << 34, SRun = 36'd1 << 35;

    logic clk = 1'b0;
    logic clr;
    int   n_checks = 0;
    int   n_fail = 0;
    logic [35:0] exp_q[$];

    control_unit_if bus ();

    control_unit #(
        .MEM_WAIT (MW),
        .ADD_OP   (5'b00011)
    ) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [35:0] observed();
        return {bus.run, bus.halted, bus.illegal_op, bus.PCout, bus.ZLowout, bus.ZHighout,
                bus.MDRout, bus.HIout, bus.LOout, bus.Cout, bus.InPortout, bus.PCin, bus.IRin,
                bus.MARin, bus.MDRin, bus.Yin, bus.ZLowIn, bus.ZHighIn, bus.HIin, bus.LOin,
                bus.OutPortIn, bus.CONin, bus.IncPC, bus.Read, bus.ramWE, bus.Gra, bus.Grb,
                bus.Grc, bus.R_in, bus.R_out, bus.BAout, bus.operation};
    endfunction

    function automatic logic [35:0] opf(input logic [4:0] o);
        return {31'd0, o};
    endfunction

    task automatic check_eq(input string tag, input logic [35:0] got, input logic [35:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // A RAM read step: MW stalled cycles with Read only, then Read with MDRin.
    function automatic void push_read();
        repeat (MW) exp_q.push_back(SRun | SRead);
        exp_q.push_back(SRun | SRead | SMdrIn);
    endfunction

    // Expected strobe vector for every cycle of one instruction, from T0 to its last step.
    function automatic void build(input logic [31:0] iv, input logic c);
        logic [4:0] o;
        o = iv[31:27];
        exp_q.push_back(SRun | SPcOut | SMarIn | SIncPc);
        push_read();
        exp_q.push_back(SRun | SMdrOut | SIrIn);
        if ((o >= OAdd && o <= OOr) || o == OAddi || o == OAndi || o == OOri) begin
            exp_q.push_back(SRun | SGrb | SROut | SYIn);
            if (o >= OAdd && o <= OOr) exp_q.push_back(SRun | SGrc | SROut | SZLowIn | opf(o));
            else                       exp_q.push_back(SRun | SCOut | SZLowIn | opf(o));
            exp_q.push_back(SRun | SZLowOut | SGra | SRIn);
        end else begin
            case (o)
                OMul, ODiv: begin
                    exp_q.push_back(SRun | SGra | SROut | SYIn);
                    exp_q.push_back(SRun | SGrb | SROut | SZLowIn | SZHighIn | opf(o));
                    exp_q.push_back(SRun | SZLowOut | SLoIn);
                    exp_q.push_back(SRun | SZHighOut | SHiIn);
                end
                ONeg, ONot: begin
                    exp_q.push_back(SRun | SGrb | SROut | SZLowIn | opf(o));
                    exp_q.push_back(SRun | SZLowOut | SGra | SRIn);
                end
                OLd, OLdi, OSt: begin
                    exp_q.push_back(SRun | SGrb | SBaOut | SYIn);
                    exp_q.push_back(SRun | SCOut | SZLowIn | opf(OAdd));
                    if (o == OLdi) begin
                        exp_q.push_back(SRun | SZLowOut | SGra | SRIn);
                    end else begin
                        exp_q.push_back(SRun | SZLowOut | SMarIn);
                        if (o == OLd) begin
                            push_read();
                            exp_q.push_back(SRun | SMdrOut | SGra | SRIn);
                        end else begin
                            exp_q.push_back(SRun | SGra | SROut | SMdrIn);
                            exp_q.push_back(SRun | SRamWe);
                        end
                    end
                end
                OBr: begin
                    exp_q.push_back(SRun | SGra | SROut | SConIn);
                    exp_q.push_back(SRun | SPcOut | SYIn);
                    exp_q.push_back(SRun | SCOut | SZLowIn | opf(OAdd));
                    exp_q.push_back(SRun | SZLowOut | (c ? SPcIn : 36'd0));
                end
                OJr:   exp_q.push_back(SRun | SGra | SROut | SPcIn);
                OIn:   exp_q.push_back(SRun | SInPortOut | SGra | SRIn);
                OOut:  exp_q.push_back(SRun | SGra | SROut | SOutPortIn);
                OMfhi: exp_q.push_back(SRun | SHiOut | SGra | SRIn);
                OMflo: exp_q.push_back(SRun | SLoOut | SGra | SRIn);
                ONop:  exp_q.push_back(SRun);
                OHalt: begin
                    exp_q.push_back(SRun);
                    repeat (20) exp_q.push_back(SHalted);
                end
                default: exp_q.push_back(SRun | SIllegal);
            endcase
        end
    endfunction

    // Runs one instruction starting at its T0; ir/con change during T0, stop optionally raised.
    task automatic run_instr(input logic [31:0] iv, input logic c, input int stop_idx);
        int idx;
        logic [35:0] e;
        build(iv, c);
        idx = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            check_eq($sformatf("ir=%h step %0d", iv, idx), observed(), e);
            if (idx == 0) begin
                bus.ir  = iv;
                bus.con = c;
            end
            if (idx == stop_idx) bus.stop = 1'b1;
            idx++;
        end
    endtask

    initial begin
        bus.ir   = 32'd0;
        bus.con  = 1'b0;
        bus.stop = 1'b0;
        clr      = 1'b1;
        #1 clr = 1'b0;
        #1 check_eq("reset state", observed(), SRun);
        @(posedge clk);
        #1 clr = 1'b1;

        run_instr(32'h18918000, 1'b0, -1);  // add r1,r2,r3
        run_instr(32'h00800010, 1'b0, -1);  // ld
        run_instr(32'h98000000, 1'b0, -1);  // br, not taken
        run_instr(32'h98000000, 1'b1, -1);  // br, taken
        run_instr(32'h78000000, 1'b0, -1);  // mul
        run_instr(32'h80000000, 1'b0, -1);  // div
        run_instr(32'h10000000, 1'b0, -1);  // st
        run_instr(32'h08000000, 1'b0, -1);  // ldi
        run_instr(32'h38000000, 1'b0, -1);  // shl
        run_instr(32'h68000000, 1'b0, -1);  // andi
        run_instr(32'h88000000, 1'b0, -1);  // neg
        run_instr(32'hA0000000, 1'b0, -1);  // jr
        run_instr(32'hB0000000, 1'b0, -1);  // in
        run_instr(32'hB8000000, 1'b0, -1);  // out
        run_instr(32'hC0000000, 1'b0, -1);  // mfhi
        run_instr(32'hA8000000, 1'b0, -1);  // undefined opcode 10101
        run_instr(32'hD0000000, 1'b0, -1);  // nop
        run_instr(32'h60000000, 1'b0, int'(MW) + 4);  // addi, stop raised in T4

        repeat (3) exp_q.push_back(36'd0);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            check_eq("stopped", observed(), exp_q.pop_front());
        end
        bus.stop = 1'b0;

        run_instr(32'hC8000000, 1'b0, -1);  // mflo, resumes right after stop drops
        run_instr(32'hD8000000, 1'b0, -1);  // halt plus 20 halted cycles

        @(negedge clk);
        clr = 1'b0;
        #1 check_eq("reset after halt", observed(), SRun);
        @(posedge clk);
        #1 clr = 1'b1;

        run_instr(32'hD0000000, 1'b0, -1);  // nop
        @(negedge clk);
        check_eq("fetch T0", observed(), SRun | SPcOut | SMarIn | SIncPc);
        @(negedge clk);
        check_eq("fetch T1", observed(), SRun | SRead);
        #2 clr = 1'b0;
        #1 check_eq("reset mid T1", observed(), SRun);
        @(posedge clk);
        #1 clr = 1'b1;

        run_instr(32'h18918000, 1'b0, -1);  // add after mid-fetch reset

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
